psum_out_reader: RTL and testbench
==================================

// Module: psum_out_reader
// PURPOSE
// - Read side of the output (PSUM) SRAM: drains psum vectors written by core into a circular region of output SRAM.
// - Chases the writer's pointer (out_wptr) with its own read pointer (out_rptr) and issues SRAM reads.
// - Presents each vector as final_psum_vector on a valid/ready stream toward the testbench/host collector.
// PARAMETERS
// - psum_bw  32  bits per psum lane
// - col      8   lanes per vector; SRAM word = psum_bw*col
// - addr_w   11  SRAM address width; circular region = 2**addr_w words
// PORTS
// - clk                input   1                  single clock, rising edge
// - reset              input   1                  synchronous, active-low; flops clear on the edge where reset==0
// - start              input   1                  pulse: IDLE->ACTIVE
// - stop               input   1                  pulse: ACTIVE->DRAIN
// - out_wptr           input   addr_w+1           writer pointer; MSB = wrap bit
// - out_rptr           output  addr_w+1           reader pointer; MSB = wrap bit
// - cen_out            output  1                  SRAM chip enable, active-low
// - wen_out            output  1                  SRAM write enable, active-low; held 1 (read only)
// - addr_out           output  addr_w             SRAM read address = out_rptr[addr_w-1:0]
// - dout_out           input   psum_bw*col        SRAM read data, valid 1 cycle after cen_out==0
// - final_psum_vector  output  psum_bw*col        output vector
// - psum_valid         output  1                  output vector valid
// - psum_ready         input   1                  consumer accepts when psum_valid & psum_ready
// - busy               output  1                  state != IDLE
// BEHAVIOUR
// - Reset values: out_rptr=0, cen_out=1, wen_out=1, addr_out=0, psum_valid=0, final_psum_vector=0, busy=0, state=IDLE.
// - Reset mid-operation: in-flight read is discarded; buffer is emptied; no vector is emitted afterwards.
// - Empty when out_wptr==out_rptr. Full is the writer's concern and is not checked here.
// - Issue rule: in ACTIVE, cen_out=0 in cycle t iff not empty and (buffer occupancy + in-flight) < 2.
//   - out_rptr increments in the same cycle.
//   - Wrap: low bits roll over 2**addr_w-1 -> 0 and the MSB toggles.
// - Latency: read issued in cycle t is captured into the 2-entry buffer at t+1; psum_valid is high at t+2 at the earliest.
// - Throughput: one vector per cycle while psum_ready==1 and the writer stays ahead.
// - Handshake: while psum_valid==1 and psum_ready==0, final_psum_vector is held stable; psum_valid never drops without a transfer.
// - Order: strict FIFO in SRAM address order.
// - FSM:
//   - IDLE: no reads. start -> ACTIVE.
//   - ACTIVE: issue per rule. stop -> DRAIN.
//   - DRAIN: no new reads; stays until in-flight==0 and buffer empty, then -> IDLE.
//   - start and stop in the same cycle: stop wins (IDLE stays IDLE; ACTIVE -> DRAIN).
//   - start in ACTIVE or DRAIN: ignored. stop in IDLE: ignored.
// - out_wptr changes while a read is being issued: the comparison uses the current-cycle value; no lookahead.
// CONFIGURATION
// - OUT_RELU_EN defined: each psum_bw lane of the buffered vector is treated as signed; negative lanes are output as 0.
//   - Applied combinationally at the buffer output; latency unchanged.
// - OUT_RELU_EN undefined: lanes pass through bit-exact.
// STRUCTURE
// - Package core_pkg:
//   - PSUM_BW, COL, ADDR_W constants.
//   - typedef psum_vec_t [PSUM_BW*COL-1:0].
//   - typedef ptr_t [ADDR_W:0].
//   - State enum {IDLE, ACTIVE, DRAIN}.
// - Sub-module psum_skid_fifo: 2-entry valid/ready buffer with occupancy output.
// - Top holds the FSM, pointer/issue logic and optional ReLU.
// TESTING
// - Reset: hold reset=0 for 3 cycles with start=1 -> all outputs at reset values, busy=0, cen_out=1.
// - Basic drain: preload SRAM addr 0..3 with lane values k+1, out_wptr=4, start, psum_ready=1
//   -> 4 vectors in order, first at cycle +2, back-to-back; out_rptr ends at 4.
// - Backpressure: psum_ready=0 for 10 cycles mid-stream -> at most 2 reads outstanding;
//   vector held stable; no loss or duplicate after ready=1.
// - Wrap: out_rptr=0x7FE, out_wptr=0x802 -> addresses read 0x7FE, 0x7FF, 0x000, 0x001; out_rptr ends at 0x802 with MSB set.
// - Stop/drain: stop during streaming with 2 in flight -> those 2 vectors are delivered, then busy=0; no further cen_out=0.
// - OUT_RELU_EN: lane = 32'hFFFF_FFF0 -> 0 when defined, unchanged when undefined; 32'h0000_0005 is unchanged in both builds.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants and types for the psum output reader slice.
// The OUT_RELU_EN build option uses relu_vec() to clamp negative lanes to zero.
package core_pkg;

   localparam int PSUM_BW = 32;
   localparam int COL     = 8;
   localparam int ADDR_W  = 11;
   localparam int VEC_W   = PSUM_BW * COL;

   typedef logic [VEC_W-1:0] psum_vec_t;
   typedef logic [ADDR_W:0]  ptr_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   // Each lane is signed; a set sign bit means the lane is negative.
   function automatic psum_vec_t relu_vec(input psum_vec_t v);
      psum_vec_t r;
      r = '0;
      for (int i = 0; i < COL; i++) begin
         r[i*PSUM_BW +: PSUM_BW] = v[i*PSUM_BW + PSUM_BW - 1] ? '0 : v[i*PSUM_BW +: PSUM_BW];
      end
      return r;
   endfunction

endpackage

// File: rtl/psum_skid_fifo.sv
// Two-entry buffer between the SRAM read data and the psum output stream.
// Capture has no backpressure: the reader only issues reads that are guaranteed a free slot.
module psum_skid_fifo
   import core_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  psum_vec_t  in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output psum_vec_t  out_data,
   output logic [1:0] count
);

   psum_vec_t  mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] cnt;
   logic       push;
   logic       pop;

   assign push      = in_valid && (cnt != 2'd2);
   assign pop       = out_valid && out_ready;
   assign out_valid = (cnt != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign count     = cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/psum_out_reader.sv
// Drains psum vectors from the circular output SRAM region, chasing out_wptr with out_rptr.
// Build option OUT_RELU_EN: clamp negative lanes to zero at the buffer output.
module psum_out_reader
   import core_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  ptr_t              out_wptr,
   output ptr_t              out_rptr,
   output logic              cen_out,
   output logic              wen_out,
   output logic [ADDR_W-1:0] addr_out,
   input  psum_vec_t         dout_out,
   output psum_vec_t         final_psum_vector,
   output logic              psum_valid,
   input  logic              psum_ready,
   output logic              busy,
   output state_t            dbg_state
);

   // Stream handshake: a vector transfers on any rising edge where psum_valid and
   // psum_ready are both high; while psum_valid is high and psum_ready is low the
   // vector is held unchanged and psum_valid stays high until it transfers.

   state_t     state_q;
   state_t     state_d;
   logic       issue;
   logic       in_flight;
   logic       empty;
   logic       pop;
   logic [1:0] fifo_count;
   logic [1:0] keep;
   logic [1:0] occ;
   psum_vec_t  fifo_data;

   assign empty = (out_wptr == out_rptr);
   assign pop   = psum_valid && psum_ready;
   // The entry leaving this cycle frees its slot now, so the stream can sustain one per cycle.
   assign keep  = fifo_count - {1'b0, pop};
   assign occ   = keep + {1'b0, in_flight};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && !stop) state_d = ACTIVE;
         ACTIVE:  if (stop) state_d = DRAIN;
         DRAIN:   if (!in_flight && (fifo_count == 2'd0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      issue = 1'b0;
      busy  = (state_q != IDLE);
      if (reset && (state_q == ACTIVE) && !empty && (occ < 2'd2)) begin
         issue = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_rptr  <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= issue;
         if (issue) begin
            out_rptr <= out_rptr + ptr_t'(1);
         end
      end
   end

   assign cen_out   = ~issue;
   assign wen_out   = 1'b1;
   assign addr_out  = out_rptr[ADDR_W-1:0];
   assign dbg_state = state_q;

   psum_skid_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_flight),
      .in_data   (dout_out),
      .out_valid (psum_valid),
      .out_ready (psum_ready),
      .out_data  (fifo_data),
      .count     (fifo_count)
   );

`ifdef OUT_RELU_EN
   assign final_psum_vector = relu_vec(fifo_data);
`else
   assign final_psum_vector = fifo_data;
`endif

endmodule

// File: tb/tb_psum_out_reader.sv
// Self-checking bench for psum_out_reader: SRAM model, writer-order expectation queue,
// per-cycle compare process and directed scenarios (reset, drain, backpressure, relu, stop, wrap).
module tb_psum_out_reader;
   import core_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              stop;
   ptr_t              out_wptr;
   ptr_t              out_rptr;
   logic              cen_out;
   logic              wen_out;
   logic [ADDR_W-1:0] addr_out;
   psum_vec_t         dout_out;
   psum_vec_t         final_psum_vector;
   logic              psum_valid;
   logic              psum_ready;
   logic              busy;
   state_t            dut_state;

   always #5 clk = ~clk;

   psum_out_reader dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .stop              (stop),
      .out_wptr          (out_wptr),
      .out_rptr          (out_rptr),
      .cen_out           (cen_out),
      .wen_out           (wen_out),
      .addr_out          (addr_out),
      .dout_out          (dout_out),
      .final_psum_vector (final_psum_vector),
      .psum_valid        (psum_valid),
      .psum_ready        (psum_ready),
      .busy              (busy),
      .dbg_state         (dut_state)
   );

   int               n_checks = 0;
   int               n_errors = 0;
   logic [VEC_W-1:0] exp_q[$];
   psum_vec_t        sram [2**ADDR_W];
   ptr_t             wp;
   ptr_t             iss_ptr;
   int               outstanding;
   logic             stall_prev;
   psum_vec_t        prev_vec;
   psum_vec_t        last_xfer;
   logic             drain_watch;

   // SRAM model: registered read data one cycle after cen_out==0
   always @(posedge clk) begin
      if (!cen_out) dout_out <= sram[addr_out];
   end

   task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic psum_vec_t model_out(input psum_vec_t v);
      psum_vec_t r;
      r = v;
`ifdef OUT_RELU_EN
      for (int i = 0; i < COL; i++) begin
         if ($signed(v[i*PSUM_BW +: PSUM_BW]) < 0) r[i*PSUM_BW +: PSUM_BW] = '0;
      end
`endif
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Writer advances: every newly written word must later appear on the stream in order.
   task automatic set_wptr(input ptr_t n);
      while (wp != n) begin
         exp_q.push_back(model_out(sram[wp[ADDR_W-1:0]]));
         wp = wp + ptr_t'(1);
      end
      out_wptr = n;
   endtask

   task automatic wait_empty(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout: %0d vectors still expected", exp_q.size());
      end
      repeat (3) tick();
   endtask

   task automatic reset_checks();
      @(negedge clk);
      chk("rst_rptr", out_rptr, 0);
      chk("rst_cen", cen_out, 1);
      chk("rst_wen", wen_out, 1);
      chk("rst_addr", addr_out, 0);
      chk("rst_valid", psum_valid, 0);
      chk("rst_vector", final_psum_vector, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", dut_state, IDLE);
   endtask

   // Per-cycle compare against the writer-order model
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         iss_ptr     = '0;
         outstanding = 0;
         stall_prev  = 1'b0;
      end else begin
         chk("wen_out", wen_out, 1);
         if (stall_prev) begin
            chk("hold_valid", psum_valid, 1);
            chk("hold_data", final_psum_vector, prev_vec);
         end
         if (!cen_out) begin
            n_checks++;
            if (out_rptr == wp) begin
               n_errors++;
               $display("FAIL issue_when_empty: rptr %h wptr %h", out_rptr, wp);
            end
            n_checks++;
            if (drain_watch) begin
               n_errors++;
               $display("FAIL issue_after_stop: addr %h", addr_out);
            end
            chk("issue_addr", addr_out, iss_ptr[ADDR_W-1:0]);
            chk("issue_rptr", out_rptr, iss_ptr);
            iss_ptr = iss_ptr + ptr_t'(1);
            outstanding++;
         end
         if (psum_valid && psum_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL extra_vector: got %h expected none", final_psum_vector);
            end else begin
               n_checks--;
               chk("vector", final_psum_vector, exp_q.pop_front());
            end
            last_xfer = final_psum_vector;
            outstanding--;
         end
         n_checks++;
         if (outstanding > 2) begin
            n_errors++;
            $display("FAIL outstanding: got %0d required at most 2", outstanding);
         end
         stall_prev = psum_valid && !psum_ready;
         prev_vec   = final_psum_vector;
      end
   end

   initial begin
      logic [31:0] lv;
      int          n;
      reset       = 1'b0;
      start       = 1'b1;
      stop        = 1'b0;
      psum_ready  = 1'b0;
      out_wptr    = '0;
      wp          = '0;
      drain_watch = 1'b0;
      for (int a = 0; a < 2**ADDR_W; a++) begin
         for (int j = 0; j < COL; j++) sram[a][j*PSUM_BW +: PSUM_BW] = 32'(a * 16 + j + 100);
      end
      for (int k = 0; k < 4; k++) begin
         lv = 32'(k + 1);
         sram[k] = {COL{lv}};
      end
      sram[12] = {{6{32'h0000_1234}}, 32'h0000_0005, 32'hFFFF_FFF0};

      // reset held 3 cycles with start asserted
      repeat (3) @(posedge clk);
      reset_checks();
      tick();
      reset = 1'b1;
      start = 1'b0;

      // basic drain of addresses 0..3
      tick();
      set_wptr(ptr_t'(4));
      psum_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("first_issue_cen", cen_out, 0);
      chk("first_issue_addr", addr_out, 0);
      chk("first_valid_t0", psum_valid, 0);
      @(negedge clk);
      chk("first_valid_t1", psum_valid, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         lv = 32'(k + 1);
         chk("b2b_valid", psum_valid, 1);
         chk("b2b_vector", final_psum_vector, {COL{lv}});
      end
      wait_empty(50);
      chk("basic_rptr", out_rptr, 4);

      // backpressure: ready low for 10 cycles mid-stream
      set_wptr(ptr_t'(12));
      repeat (3) tick();
      psum_ready = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      chk("bp_rptr", out_rptr, 7);
      chk("bp_valid", psum_valid, 1);
      tick();
      psum_ready = 1'b1;
      wait_empty(50);
      chk("bp_end_rptr", out_rptr, 12);

      // relu lanes
      set_wptr(ptr_t'(13));
      wait_empty(20);
`ifdef OUT_RELU_EN
      chk("relu_lane0", last_xfer[31:0], 32'h0000_0000);
`else
      chk("relu_lane0", last_xfer[31:0], 32'hFFFF_FFF0);
`endif
      chk("relu_lane1", last_xfer[63:32], 32'h0000_0005);
      chk("relu_lane7", last_xfer[255:224], 32'h0000_1234);

      // stop with two reads outstanding
      psum_ready = 1'b0;
      set_wptr(ptr_t'(23));
      repeat (5) tick();
      @(negedge clk);
      chk("stop_pre_rptr", out_rptr, 15);
      tick();
      stop = 1'b1;
      drain_watch = 1'b1;
      tick();
      stop = 1'b0;
      psum_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (psum_valid && psum_ready) n++;
         if (!busy) break;
      end
      chk("drain_count", n, 2);
      chk("drain_busy", busy, 0);
      chk("drain_rptr", out_rptr, 15);
      tick();
      drain_watch = 1'b0;

      // start and stop together in IDLE: stays IDLE
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      chk("startstop_busy", busy, 0);
      chk("startstop_state", dut_state, IDLE);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_empty(100);
      chk("resume_rptr", out_rptr, 23);

      // reset mid-operation with buffered data
      psum_ready = 1'b0;
      set_wptr(ptr_t'(30));
      repeat (6) tick();
      reset    = 1'b0;
      start    = 1'b1;
      wp       = '0;
      out_wptr = '0;
      repeat (2) tick();
      reset_checks();
      tick();
      reset      = 1'b1;
      start      = 1'b0;
      psum_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("post_rst_valid", psum_valid, 0);
      end
      chk("post_rst_busy", busy, 0);

      // wrap across the end of the region
      tick();
      start = 1'b1;
      set_wptr(ptr_t'(12'h7FE));
      tick();
      start = 1'b0;
      wait_empty(2300);
      chk("wrap_pre_rptr", out_rptr, 12'h7FE);
      set_wptr(ptr_t'(12'h802));
      wait_empty(50);
      chk("wrap_rptr", out_rptr, 12'h802);
      chk("wrap_msb", out_rptr[ADDR_W], 1);
      lv = 32'd2;
      chk("wrap_last_vector", last_xfer, {COL{lv}});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
